ntt_seq_ctrl: RTL and testbench
===============================

# ntt_seq_ctrl

Sequencer that owns the shared single-port BRAM and the `ntt` core for one transform. On `start` it streams the N-word input vector and the N×N twiddle matrix out of BRAM into the core's load port, then releases the core from reset and waits for `ntt_done`. It then writes the N result words back to BRAM and pulses `done`. It is the only BRAM master while `busy` is high.

## Interface
Parameters:
- `N`, 64: transform length.
- `DW`, 64: BRAM data width.
- `AW`, 15: BRAM byte-address width.
- `X_BASE`, 0: word base of the input vector.
- `Y_BASE`, 64: word base of the result vector.
- `W_BASE`, 128: word base of the twiddle matrix, row-major.
- `RD_LAT`, 1: BRAM read latency in cycles, from address to `bram_dout`.
- `TIMEOUT`, 65535: maximum number of RUN cycles.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset (synchronous, active-high; clock `clk`).
- `start` in 1: begin a transform; honoured only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: set on timeout, cleared on the next accepted `start`.
- `bram_addr` out AW: byte address, equal to (word address << 2) truncated to AW.
- `bram_en` out 1: BRAM enable.
- `bram_we` out 1: BRAM write enable.
- `bram_din` out DW: write data.
- `bram_dout` in DW: read data.
- `ld_valid` out 1: load strobe to the core.
- `ld_sel` out 1: load target; 0 = x, 1 = w.
- `ld_idx` out 12: element index; x index is `i`, w index is row×N+col.
- `ld_data` out DW: load data; for w only bits [7:0] are meaningful.
- `ntt_rst` out 1: core reset.
- `ntt_done` in 1: core result ready.
- `y_idx` out 6: result index presented to the core.
- `y_data` in DW: core result at `y_idx`, combinational from `y_idx`.

## Operation
- States: IDLE → LD_X → LD_W → RUN → WB → FIN → IDLE.
- IDLE:
  - `bram_en`=0, `ntt_rst`=1.
  - `start`=1 clears `err` and enters LD_X.
- LD_X:
  - Issue counter `ic` steps 0..N-1, one read per cycle at word X_BASE+`ic`.
  - `bram_en`=1 while issuing.
  - Each read returns RD_LAT cycles later. On return: `ld_valid`=1, `ld_sel`=0, `ld_idx`=return count `rc`, `ld_data`=`bram_dout`.
  - Exit to LD_W when `rc` reaches N, i.e. after the pipeline drains. No overlap between LD_X and LD_W.
- LD_W:
  - Same mechanism over N×N reads at W_BASE+`ic`, with `ld_sel`=1.
  - Exit to RUN when `rc` reaches N×N.
- RUN:
  - `ntt_rst`=0; `bram_en`=0.
  - `ntt_done` is ignored on the first RUN cycle.
  - `ntt_done`=1 → WB.
  - If the RUN cycle count reaches TIMEOUT, set `err`=1 and go straight to FIN (no writeback).
- WB:
  - `ntt_rst` stays 0.
  - For `i` = 0..N-1, one per cycle: `y_idx`=`i`, `bram_en`=1, `bram_we`=1, `bram_addr`=(Y_BASE+`i`)<<2, `bram_din`=`y_data`.
  - Address and data are presented in the same cycle.
- FIN:
  - `done`=1 for one cycle.
  - `ntt_rst` returns to 1.
  - Next state is IDLE.
- `start` outside IDLE is ignored.
- Counters are wide enough for N×N+RD_LAT with no wrap.

## Timing
- Reset values:
  - State IDLE.
  - `busy`, `done`, `err`, `bram_en`, `bram_we`, `ld_valid` all 0.
  - `ntt_rst`=1.
  - `bram_addr`, `bram_din`, `ld_idx`, `ld_data`, `y_idx` all 0.
- `start` sampled at cycle 0 → LD_X from cycle 1; first read address is issued in cycle 1.
- First `ld_valid` occurs in cycle 1+RD_LAT.
- Total latency from `start` to `done` is 1 + (N+RD_LAT) + (N²+RD_LAT) + R + N + 1 cycles, where R is the number of RUN cycles.
- `rst` mid-operation: on the next edge the block is in IDLE with reset values. Any in-flight returns are discarded, and `ld_valid` does not assert for them.
- `bram_we` is never 1 outside WB.
- `ld_valid` is never 1 outside LD_X/LD_W.

## Structure
- Package `ntt_seq_pkg` holds:
  - `state_t` enum.
  - Default base/size localparams.
  - Byte-shift constant (2).
- Sub-module `ntt_seq_rdpipe`: RD_LAT-deep shift register of {valid, idx, sel} tagging each issued read. Its output drives `ld_valid`/`ld_idx`/`ld_sel`.

## Test plan
- Reset: hold `rst` 3 cycles → all outputs at their reset values, `ntt_rst`=1, `busy`=0.
- Load with RD_LAT=1, BRAM model with word k = k:
  - x: addresses 0,4,…,252; `ld_idx` i paired with `ld_data`=i.
  - w: starts at byte 512 and ends at (128+4095)<<2=16892.
  - `ld_valid` count is 64 for x and 4096 for w.
- RD_LAT=3: last x `ld_valid` (idx 63) occurs before the first w address is issued; no lost or duplicated index.
- Writeback: `ntt_done` 10 cycles into RUN, `y_data`=`y_idx`×3 → 64 writes to 256+4i with din 3i, then a single `done` pulse, `err`=0.
- Timeout: TIMEOUT=100, `ntt_done` tied 0 → `done` at RUN+100 cycles, `err`=1, zero BRAM writes.
- Mid-operation reset and busy-start:
  - `rst` during LD_W → IDLE next cycle, `bram_en`=0.
  - A new `start` reloads from x index 0.
  - `start` pulsed during RUN has no effect.

Source files
------------

// File: rtl/ntt_seq_pkg.sv
`default_nettype none
// ============================================================
// ntt_seq_pkg : shared types and defaults for the NTT sequencer
// Rev 1.0
// ============================================================
package ntt_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LD_X = 3'd1,
        S_LD_W = 3'd2,
        S_RUN  = 3'd3,
        S_WB   = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    localparam int DEF_N       = 64;
    localparam int DEF_DW      = 64;
    localparam int DEF_AW      = 15;
    localparam int DEF_X_BASE  = 0;
    localparam int DEF_Y_BASE  = 64;
    localparam int DEF_W_BASE  = 128;
    localparam int DEF_RD_LAT  = 1;
    localparam int DEF_TIMEOUT = 65535;

    localparam int BYTE_SHIFT = 2;
    localparam int LD_IDX_W   = 12;
    localparam int Y_IDX_W    = 6;

endpackage
`default_nettype wire

// File: rtl/ntt_seq_rdpipe.sv
`default_nettype none
// ============================================================
// ntt_seq_rdpipe : DEPTH-stage tag pipe matching BRAM read latency
// Rev 1.0
// ============================================================
module ntt_seq_rdpipe #(
    parameter int DEPTH = 1,
    parameter int IW    = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [IW-1:0] in_idx,
    input  logic          in_sel,
    output logic          out_valid,
    output logic [IW-1:0] out_idx,
    output logic          out_sel
);

    logic [DEPTH-1:0]         r_valid;
    logic [DEPTH-1:0][IW-1:0] r_idx;
    logic [DEPTH-1:0]         r_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_idx   <= '0;
            r_sel   <= '0;
        end else begin
            // Idle slots carry zeros so the load port rests at its reset values.
            r_valid[0] <= in_valid;
            r_idx[0]   <= in_valid ? in_idx : '0;
            r_sel[0]   <= in_valid & in_sel;
            for (int k = DEPTH - 1; k > 0; k--) begin
                r_valid[k] <= r_valid[k-1];
                r_idx[k]   <= r_idx[k-1];
                r_sel[k]   <= r_sel[k-1];
            end
        end
    end

    assign out_valid = r_valid[DEPTH-1];
    assign out_idx   = r_idx[DEPTH-1];
    assign out_sel   = r_sel[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/ntt_seq_ctrl.sv
`default_nettype none
// ============================================================
// ntt_seq_ctrl : BRAM -> NTT core load, run and writeback sequencer
// Rev 1.0
// ============================================================
module ntt_seq_ctrl
    import ntt_seq_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int DW      = DEF_DW,
    parameter int AW      = DEF_AW,
    parameter int X_BASE  = DEF_X_BASE,
    parameter int Y_BASE  = DEF_Y_BASE,
    parameter int W_BASE  = DEF_W_BASE,
    parameter int RD_LAT  = DEF_RD_LAT,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [AW-1:0]       bram_addr,
    output logic                bram_en,
    output logic                bram_we,
    output logic [DW-1:0]       bram_din,
    input  logic [DW-1:0]       bram_dout,
    output logic                ld_valid,
    output logic                ld_sel,
    output logic [LD_IDX_W-1:0] ld_idx,
    output logic [DW-1:0]       ld_data,
    output logic                ntt_rst,
    input  logic                ntt_done,
    output logic [Y_IDX_W-1:0]  y_idx,
    input  logic [DW-1:0]       y_data
);

    localparam int NN = N * N;
    localparam int CW = $clog2(NN + RD_LAT + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t                r_state;
    logic [CW-1:0]         r_ic;
    logic [CW-1:0]         r_rc;
    logic [TW-1:0]         r_run_cnt;
    logic                  r_iss_valid;
    logic [LD_IDX_W-1:0]   r_iss_idx;
    logic                  r_iss_sel;

    logic [CW-1:0]         w_len;
    logic [31:0]           w_base;
    logic                  w_last_ret;

    function automatic logic [AW-1:0] to_byte(input logic [31:0] word);
        logic [31:0] b;
        b = word << BYTE_SHIFT;
        return b[AW-1:0];
    endfunction

    ntt_seq_rdpipe #(
        .DEPTH (RD_LAT),
        .IW    (LD_IDX_W)
    ) u_rdpipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (r_iss_valid),
        .in_idx    (r_iss_idx),
        .in_sel    (r_iss_sel),
        .out_valid (ld_valid),
        .out_idx   (ld_idx),
        .out_sel   (ld_sel)
    );

    assign w_len      = (r_state == S_LD_W) ? CW'(NN) : CW'(N);
    assign w_base     = (r_state == S_LD_W) ? 32'(W_BASE) : 32'(X_BASE);
    assign w_last_ret = ld_valid && (r_rc == w_len - CW'(1));

    assign busy     = (r_state != S_IDLE);
    assign ld_data  = ld_valid ? bram_dout : '0;
    // The core result is combinational from y_idx, so data rides with the address.
    assign bram_din = bram_we ? y_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ic        <= '0;
            r_rc        <= '0;
            r_run_cnt   <= '0;
            r_iss_valid <= 1'b0;
            r_iss_idx   <= '0;
            r_iss_sel   <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            bram_en     <= 1'b0;
            bram_we     <= 1'b0;
            bram_addr   <= '0;
            ntt_rst     <= 1'b1;
            y_idx       <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    bram_en     <= 1'b0;
                    bram_we     <= 1'b0;
                    r_iss_valid <= 1'b0;
                    ntt_rst     <= 1'b1;
                    if (start) begin
                        err         <= 1'b0;
                        r_state     <= S_LD_X;
                        r_ic        <= CW'(1);
                        r_rc        <= '0;
                        bram_en     <= 1'b1;
                        bram_addr   <= to_byte(32'(X_BASE));
                        r_iss_valid <= 1'b1;
                        r_iss_idx   <= '0;
                        r_iss_sel   <= 1'b0;
                    end
                end
                S_LD_X, S_LD_W: begin
                    if (ld_valid) begin
                        r_rc <= r_rc + CW'(1);
                    end
                    if (r_ic < w_len) begin
                        bram_en     <= 1'b1;
                        bram_addr   <= to_byte(w_base + 32'(r_ic));
                        r_iss_valid <= 1'b1;
                        r_iss_idx   <= LD_IDX_W'(r_ic);
                        r_iss_sel   <= (r_state == S_LD_W);
                        r_ic        <= r_ic + CW'(1);
                    end else begin
                        bram_en     <= 1'b0;
                        r_iss_valid <= 1'b0;
                    end
                    // Phase ends only once every tagged read has come back.
                    if (w_last_ret) begin
                        r_rc <= '0;
                        if (r_state == S_LD_X) begin
                            r_state     <= S_LD_W;
                            r_ic        <= CW'(1);
                            bram_en     <= 1'b1;
                            bram_addr   <= to_byte(32'(W_BASE));
                            r_iss_valid <= 1'b1;
                            r_iss_idx   <= '0;
                            r_iss_sel   <= 1'b1;
                        end else begin
                            r_state     <= S_RUN;
                            bram_en     <= 1'b0;
                            r_iss_valid <= 1'b0;
                            ntt_rst     <= 1'b0;
                            r_run_cnt   <= '0;
                        end
                    end
                end
                S_RUN: begin
                    r_run_cnt <= r_run_cnt + TW'(1);
                    if ((r_run_cnt != '0) && ntt_done) begin
                        r_state   <= S_WB;
                        y_idx     <= '0;
                        bram_en   <= 1'b1;
                        bram_we   <= 1'b1;
                        bram_addr <= to_byte(32'(Y_BASE));
                    end else if (r_run_cnt == TW'(TIMEOUT - 1)) begin
                        r_state <= S_FIN;
                        err     <= 1'b1;
                        done    <= 1'b1;
                        ntt_rst <= 1'b1;
                    end
                end
                S_WB: begin
                    if (y_idx == Y_IDX_W'(N - 1)) begin
                        r_state <= S_FIN;
                        bram_en <= 1'b0;
                        bram_we <= 1'b0;
                        done    <= 1'b1;
                        ntt_rst <= 1'b1;
                        y_idx   <= '0;
                    end else begin
                        y_idx     <= y_idx + Y_IDX_W'(1);
                        bram_addr <= to_byte(32'(Y_BASE) + 32'(y_idx) + 32'd1);
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ntt_seq_ctrl.sv
`default_nettype none
// ============================================================
// tb_ntt_seq_ctrl : scoreboard bench for the NTT sequencer
// Rev 1.0
// ============================================================
module tb_ntt_seq_ctrl;

    localparam int N  = 64;
    localparam int NN = N * N;
    localparam int DW = 64;
    localparam int AW = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: RD_LAT=1, TIMEOUT=100
    logic          start_a = 1'b0, ntt_done_a = 1'b0;
    logic          busy_a, done_a, err_a, en_a, we_a, ldv_a, ldsel_a, nrst_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] din_a, ldd_a, yd_a;
    logic [DW-1:0] dout_a = '0;
    logic [11:0]   ldi_a;
    logic [5:0]    yi_a;

    ntt_seq_ctrl #(.RD_LAT(1), .TIMEOUT(100)) dut (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a), .err(err_a),
        .bram_addr(addr_a), .bram_en(en_a), .bram_we(we_a), .bram_din(din_a), .bram_dout(dout_a),
        .ld_valid(ldv_a), .ld_sel(ldsel_a), .ld_idx(ldi_a), .ld_data(ldd_a),
        .ntt_rst(nrst_a), .ntt_done(ntt_done_a), .y_idx(yi_a), .y_data(yd_a)
    );

    assign yd_a = DW'(yi_a) * 64'd3;
    always @(posedge clk) if (en_a && !we_a) dout_a <= DW'(addr_a >> 2);

    // Instance B: RD_LAT=3
    logic          start_b = 1'b0;
    logic          ntt_done_b = 1'b1;
    logic          busy_b, done_b, err_b, en_b, we_b, ldv_b, ldsel_b, nrst_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] din_b, ldd_b;
    logic [DW-1:0] yd_b = '0;
    logic [DW-1:0] p1_b = '0, p2_b = '0, dout_b = '0;
    logic [11:0]   ldi_b;
    logic [5:0]    yi_b;

    ntt_seq_ctrl #(.RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .err(err_b),
        .bram_addr(addr_b), .bram_en(en_b), .bram_we(we_b), .bram_din(din_b), .bram_dout(dout_b),
        .ld_valid(ldv_b), .ld_sel(ldsel_b), .ld_idx(ldi_b), .ld_data(ldd_b),
        .ntt_rst(nrst_b), .ntt_done(ntt_done_b), .y_idx(yi_b), .y_data(yd_b)
    );

    always @(posedge clk) begin
        if (en_b && !we_b) p1_b <= DW'(addr_b >> 2);
        p2_b   <= p1_b;
        dout_b <= p2_b;
    end

    // Scoreboards
    logic [76:0] lq_a[$], lq_b[$];
    logic [14:0] aq_a[$];
    logic [78:0] wq_a[$];

    int first_rd_a = -1, first_ld_a = -1, r0_a = -1, done_cyc_a = 0;
    int n_wr_a = 0, cnt_x_a = 0, cnt_w_a = 0, n_done_a = 0;
    logic prev_nrst_a = 1'b1;
    int cnt_x_b = 0, cnt_w_b = 0, n_done_b = 0;
    logic seen_w_b = 1'b0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_loads_a();
        for (int i = 0; i < N; i++) begin
            lq_a.push_back({1'b0, 12'(i), 64'(i)});
            aq_a.push_back(15'(i * 4));
        end
        for (int j = 0; j < NN; j++) begin
            lq_a.push_back({1'b1, 12'(j), 64'(128 + j)});
            aq_a.push_back(15'((128 + j) * 4));
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (en_a && !we_a) begin
                if (first_rd_a < 0) first_rd_a = cyc;
                if (aq_a.size() == 0) chk("rd_extra", 128'(aq_a.size()), 128'(1));
                else chk("rd_addr", 128'(addr_a), 128'(aq_a.pop_front()));
            end
            if (ldv_a) begin
                if (first_ld_a < 0) first_ld_a = cyc;
                if (!nrst_a) chk("ldv_in_run", 128'(ldv_a), 128'(0));
                if (ldsel_a) cnt_w_a++; else cnt_x_a++;
                if (lq_a.size() == 0) chk("ld_extra", 128'(lq_a.size()), 128'(1));
                else chk("ld", 128'({ldsel_a, ldi_a, ldd_a}), 128'(lq_a.pop_front()));
            end
            if (we_a) begin
                n_wr_a++;
                if (nrst_a) chk("we_outside_wb", 128'(nrst_a), 128'(0));
                if (wq_a.size() == 0) chk("wb_extra", 128'(wq_a.size()), 128'(1));
                else chk("wb", 128'({addr_a, din_a}), 128'(wq_a.pop_front()));
            end
            if (done_a) begin
                n_done_a++;
                done_cyc_a = cyc;
            end
            if (prev_nrst_a && !nrst_a) r0_a = cyc;
        end
        prev_nrst_a = nrst_a;
    end

    always @(negedge clk) begin
        if (!rst) begin
            // Checked before this cycle's return is counted: a same-cycle overlap fails.
            if (en_b && !we_b && addr_b >= 15'd512 && !seen_w_b) begin
                seen_w_b = 1'b1;
                chk("x_before_w", 128'(cnt_x_b), 128'(N));
            end
            if (ldv_b) begin
                if (ldsel_b) cnt_w_b++; else cnt_x_b++;
                if (lq_b.size() == 0) chk("ld3_extra", 128'(lq_b.size()), 128'(1));
                else chk("ld3", 128'({ldsel_b, ldi_b, ldd_b}), 128'(lq_b.pop_front()));
            end
            if (done_b) n_done_b++;
        end
    end

    // done_at < 0 leaves ntt_done low to force the timeout path.
    task automatic xform_a(input int done_at, input bit poke);
        int c0, nd;
        push_loads_a();
        first_rd_a = -1; first_ld_a = -1; r0_a = -1;
        n_wr_a = 0; cnt_x_a = 0; cnt_w_a = 0; nd = n_done_a;
        start_a = 1'b1; c0 = cyc;
        tick();
        start_a = 1'b0;
        chk("err_clr", 128'(err_a), 128'(0));
        for (int k = 0; k < 6000 && r0_a < 0; k++) tick();
        chk("run_start", 128'(r0_a), 128'(c0 + 1 + (N + 1) + (NN + 1)));
        chk("first_rd", 128'(first_rd_a), 128'(c0 + 1));
        chk("first_ld", 128'(first_ld_a), 128'(c0 + 2));
        if (done_at >= 0) begin
            for (int k = 0; k < done_at; k++) begin
                start_a = poke && (k == 3);
                tick();
            end
            start_a = 1'b0;
            ntt_done_a = 1'b1;
            for (int i = 0; i < N; i++) wq_a.push_back({15'((64 + i) * 4), 64'(3 * i)});
        end else begin
            for (int k = 0; k < 6; k++) begin
                start_a = poke && (k == 3);
                tick();
            end
            start_a = 1'b0;
        end
        for (int k = 0; k < 400 && n_done_a == nd; k++) tick();
        ntt_done_a = 1'b0;
        chk("done_seen", 128'(n_done_a - nd), 128'(1));
        chk("x_count", 128'(cnt_x_a), 128'(N));
        chk("w_count", 128'(cnt_w_a), 128'(NN));
        if (done_at >= 0) begin
            chk("done_lat", 128'(done_cyc_a - r0_a), 128'(done_at + 1 + N));
            chk("n_writes", 128'(n_wr_a), 128'(N));
            chk("err_ok", 128'(err_a), 128'(0));
        end else begin
            chk("timeout_lat", 128'(done_cyc_a - r0_a), 128'(100));
            chk("timeout_wr", 128'(n_wr_a), 128'(0));
            chk("timeout_err", 128'(err_a), 128'(1));
        end
        chk("lq_left", 128'(lq_a.size()), 128'(0));
        chk("wq_left", 128'(wq_a.size()), 128'(0));
        repeat (3) tick();
        chk("single_done", 128'(n_done_a - nd), 128'(1));
        chk("idle_after", 128'(busy_a), 128'(0));
    endtask

    initial begin
        int nd;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_busy", 128'(busy_a), 128'(0));
        chk("rst_done", 128'(done_a), 128'(0));
        chk("rst_err", 128'(err_a), 128'(0));
        chk("rst_en_we", 128'({en_a, we_a}), 128'(0));
        chk("rst_ldv", 128'(ldv_a), 128'(0));
        chk("rst_nrst", 128'(nrst_a), 128'(1));
        chk("rst_addr_din", 128'({addr_a, din_a}), 128'(0));
        chk("rst_ld", 128'({ldsel_a, ldi_a, ldd_a}), 128'(0));
        chk("rst_yidx", 128'(yi_a), 128'(0));
        chk("rst_b", 128'({busy_b, done_b, err_b, en_b, we_b, ldv_b, nrst_b}), 128'(7'b0000001));
        rst = 1'b0;
        tick();

        // RD_LAT=3 load ordering
        for (int i = 0; i < N; i++) lq_b.push_back({1'b0, 12'(i), 64'(i)});
        for (int j = 0; j < NN; j++) lq_b.push_back({1'b1, 12'(j), 64'(128 + j)});
        nd = n_done_b;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int k = 0; k < 6000 && n_done_b == nd; k++) tick();
        chk("b_done", 128'(n_done_b - nd), 128'(1));
        chk("b_x_cnt", 128'(cnt_x_b), 128'(N));
        chk("b_w_cnt", 128'(cnt_w_b), 128'(NN));
        chk("b_seen_w", 128'(seen_w_b), 128'(1));
        chk("b_lq_left", 128'(lq_b.size()), 128'(0));

        // Full transform with writeback
        xform_a(10, 1'b0);

        // Reset during LD_W
        push_loads_a();
        cnt_x_a = 0; cnt_w_a = 0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 0; k < 2000 && cnt_w_a < 100; k++) tick();
        chk("midrst_in_ldw", 128'(cnt_w_a >= 100), 128'(1));
        rst = 1'b1;
        tick();
        chk("midrst_busy", 128'(busy_a), 128'(0));
        chk("midrst_en", 128'(en_a), 128'(0));
        chk("midrst_ldv", 128'(ldv_a), 128'(0));
        chk("midrst_nrst", 128'(nrst_a), 128'(1));
        rst = 1'b0;
        lq_a.delete();
        aq_a.delete();
        tick();
        chk("postrst_ldv", 128'(ldv_a), 128'(0));

        // Reload from x index 0, with a start poked during RUN
        xform_a(12, 1'b1);

        // Timeout, then a normal run clears err
        xform_a(-1, 1'b1);
        xform_a(5, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
